// File: rtl/addsub_arbiter_pkg.sv
// Shared encodings for the two-requester add/sub arbiter.
// State encoding and requester-id width used by the top and the bench.
package addsub_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned ID_W = 1;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StExec = ST_EXEC,
      StResp = ST_RESP
   } state_e;

endpackage

// File: rtl/addsub_arbiter_add_or_sub.sv
// Shared add/subtract datapath: {cout, out} = in1 + (sub ? ~in2 + 1 : in2).
// For subtract, cout = 1 means no borrow.
module addsub_arbiter_add_or_sub #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] out_o,
   output logic             cout_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] opb;

   always_comb begin
      opb = {1'b0, (sub_i ? ~in2_i : in2_i)};
      sum = {1'b0, in1_i} + opb + {{WIDTH{1'b0}}, sub_i};
   end

   assign out_o  = sum[WIDTH-1:0];
   assign cout_o = sum[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// Accept in IDLE, compute in EXEC, hold the tagged result in RESP until taken.
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_in1,
   input  logic [WIDTH-1:0] req0_in2,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_in1,
   input  logic [WIDTH-1:0] req1_in2,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_cout,
   output logic [ID_W-1:0]  rsp_id
);

   state_e            state_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [WIDTH-1:0]  op_in1_q;
   logic [WIDTH-1:0]  op_in2_q;
   logic              op_sub_q;
   logic [ID_W-1:0]   op_id_q;
   logic              rsp_valid_q;
   logic [WIDTH-1:0]  rsp_out_q;
   logic              rsp_cout_q;
   logic [ID_W-1:0]   rsp_id_q;

   logic              grant_vld;
   logic [ID_W-1:0]   grant_id;
   logic [WIDTH-1:0]  sel_in1;
   logic [WIDTH-1:0]  sel_in2;
   logic              sel_sub;
   logic [WIDTH-1:0]  alu_out;
   logic              alu_cout;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_vld = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
      sel_in1 = grant_id[0] ? req1_in1 : req0_in1;
      sel_in2 = grant_id[0] ? req1_in2 : req0_in2;
      sel_sub = grant_id[0] ? req1_sub : req0_sub;
   end

   assign req0_ready = grant_vld && !grant_id[0];
   assign req1_ready = grant_vld && grant_id[0];

   addsub_arbiter_add_or_sub #(
      .WIDTH (WIDTH)
   ) u_add_or_sub (
      .in1_i  (op_in1_q),
      .in2_i  (op_in2_q),
      .sub_i  (op_sub_q),
      .out_o  (alu_out),
      .cout_o (alu_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         op_in1_q     <= '0;
         op_in2_q     <= '0;
         op_sub_q     <= 1'b0;
         op_id_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_out_q    <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_id_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_vld) begin
                  op_in1_q <= sel_in1;
                  op_in2_q <= sel_in2;
                  op_sub_q <= sel_sub;
                  op_id_q  <= grant_id;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               rsp_out_q   <= alu_out;
               rsp_cout_q  <= alu_cout;
               rsp_id_q    <= op_id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q  <= 1'b0;
                  last_grant_q <= rsp_id_q;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_out   = rsp_out_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: single ops, contention, backpressure, reset.
module tb_addsub_arbiter;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_in1;
   logic [WIDTH-1:0] req0_in2;
   logic             req0_sub;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_in1;
   logic [WIDTH-1:0] req1_in2;
   logic             req1_sub;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_out;
   logic             rsp_cout;
   logic [0:0]       rsp_id;

   int n_checks;
   int n_errors;

   addsub_arbiter #(
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_in1   (req0_in1),
      .req0_in2   (req0_in2),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_in1   (req1_in1),
      .req1_in2   (req1_in2),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_out    (rsp_out),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept-cycle ready check, then T+1 idle response, then T+2 result check.
   task automatic single_op(input string tag, input logic id, input logic [3:0] a,
                            input logic [3:0] b, input logic sub,
                            input logic [3:0] exp_out, input logic exp_cout);
      @(posedge clk); #1;
      if (id) begin
         req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_sub = sub;
      end else begin
         req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_sub = sub;
      end
      @(negedge clk);
      chk({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, !id});
      chk({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, id});
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_t1_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk({tag, "_t2_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_out"}, {28'd0, rsp_out}, {28'd0, exp_out});
      chk({tag, "_cout"}, {31'd0, rsp_cout}, {31'd0, exp_cout});
      chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
      @(negedge clk);
      chk({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int both_hi;
      int got;
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_sub = 1'b0;
      rsp_ready  = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_out", {28'd0, rsp_out}, 32'd0);
      chk("rst_cout", {31'd0, rsp_cout}, 32'd0);
      chk("rst_id", {31'd0, rsp_id}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1100+1111 = 1_1011; 1111-1100 = 1_0011; 1100-1111 = 0_1101.
      single_op("add0", 1'b0, 4'b1100, 4'b1111, 1'b0, 4'b1011, 1'b1);
      single_op("sub1", 1'b1, 4'b1111, 4'b1100, 1'b1, 4'b0011, 1'b1);
      single_op("subb", 1'b0, 4'b1100, 4'b1111, 1'b1, 4'b1101, 1'b0);

      // Contention straight out of reset: ids 0,1,0,1 with 2,4,2,4.
      @(posedge clk); #1;
      rst = 1'b1;
      req0_valid = 1'b1; req0_in1 = 4'd1; req0_in2 = 4'd1; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_in1 = 4'd2; req1_in2 = 4'd2; req1_sub = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      both_hi = 0;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         for (int c = 0; c < 12 && got == 0; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_hi++;
            if (rsp_valid) got = 1;
         end
         chk("cont_seen", got, 1);
         chk("cont_id", {31'd0, rsp_id}, k % 2);
         chk("cont_out", {28'd0, rsp_out}, (k % 2 == 1) ? 32'd4 : 32'd2);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("cont_one_ready", both_hi, 0);

      // Backpressure: 0011+0100 held for 5 cycles while req1 waits.
      @(negedge clk);
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_in1 = 4'd3; req0_in2 = 4'd4; req0_sub = 1'b0;
      @(negedge clk);
      chk("bp_accept", {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_in1 = 4'd2; req1_in2 = 4'd2; req1_sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_out", {28'd0, rsp_out}, 32'd7);
         chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
         chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      chk("bp_last_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      chk("bp_released", {31'd0, rsp_valid}, 32'd0);
      chk("bp_idle_grant1", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("bp_no_dup", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("bp_next_out", {28'd0, rsp_out}, 32'd4);
      chk("bp_next_id", {31'd0, rsp_id}, 32'd1);

      // Reset during EXEC, both requesters waiting.
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_in1 = 4'd9; req1_in2 = 4'd1; req1_sub = 1'b1;
      @(negedge clk);
      chk("rst_accept1", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_in1 = 4'd6; req1_in2 = 4'd6; req1_sub = 1'b0;
      req0_valid = 1'b1; req0_in1 = 4'd5; req0_in2 = 4'd3; req0_sub = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("arst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_out", {28'd0, rsp_out}, 32'd0);
      chk("arst_id", {31'd0, rsp_id}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("arst_tie0", {31'd0, req0_ready}, 32'd1);
      chk("arst_tie1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("arst_no_stale", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("arst_valid2", {31'd0, rsp_valid}, 32'd1);
      chk("arst_out2", {28'd0, rsp_out}, 32'd8);
      chk("arst_cout2", {31'd0, rsp_cout}, 32'd0);
      chk("arst_id2", {31'd0, rsp_id}, 32'd0);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one add_or_sub datapath between two requesters. Each requester presents operands and an add/sub select on a valid/ready handshake. The block grants one request, drives the shared unit, registers the result, and returns it on a single response channel tagged with the requester id. It sits between the two client blocks and the single add_or_sub instance.

Parameters:
- WIDTH, 4, operand and result width; must match the add_or_sub instance.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_in1  input  WIDTH  requester 0 operand A.
- req0_in2  input  WIDTH  requester 0 operand B.
- req0_sub  input  1  requester 0 select: 0 = add, 1 = subtract.
- req1_valid, req1_ready, req1_in1, req1_in2, req1_sub  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_out  output  WIDTH  result.
- rsp_cout  output  1  carry out. For subtract, 1 means no borrow.
- rsp_id  output  1  requester that owns the result.

Behaviour:
- Interface rule: one clock, clk. Reset rst is asynchronous and active-high.
- On reset, all outputs are 0: req*_ready, rsp_valid, rsp_out, rsp_cout, rsp_id. Internal state goes to IDLE and last_grant goes to 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - The granted reqN_ready is driven high combinationally in the same cycle; at most one ready is high in any cycle.
  - Latch in1, in2, sub and the grant id into operand registers, then go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - Operand registers drive the add_or_sub instance.
  - Add: {cout, out} = in1 + in2.
  - Subtract: {cout, out} = in1 + ~in2 + 1, using WIDTH+1-bit arithmetic.
  - Register out, cout and id into the rsp_* registers, then go to RESP.
  - req*_ready is 0.
- RESP:
  - rsp_valid = 1; rsp_out, rsp_cout and rsp_id stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: set last_grant to rsp_id and go to IDLE. rsp_valid falls the next cycle.
  - req*_ready is 0.
- Latency: request accepted at cycle T gives rsp_valid at T+2. Best-case throughput is one operation every 3 cycles.
- Requests are not stored beyond the accept cycle. A requester must hold valid and its operands until it sees ready.
- A valid that drops before grant is simply not served; there is no error.
- Backpressure: if rsp_ready stays low, the block stays in RESP indefinitely and accepts no new request.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- Reset mid-operation discards any in-flight operation and any unconsumed response; no response is issued for it.
- Wrap-around: results are modulo 2^WIDTH. Overflow is not flagged; only the carry is reported.

Decomposition:
- Shared package holds:
  - localparams ST_IDLE, ST_EXEC, ST_RESP, as a 2-bit state encoding.
  - ID_W = 1.
- One sub-module: the existing add_or_sub, instantiated once as the shared datapath. The arbiter never computes arithmetic itself.

Test Plan:
1. Single add, WIDTH=4: req0 in1=1100, in2=1111, sub=0 → req0_ready in accept cycle; at T+2 rsp_valid=1, rsp_out=1011, rsp_cout=1, rsp_id=0.
2. Single subtract without borrow: req1 in1=1111, in2=1100, sub=1 → rsp_out=0011, rsp_cout=1, rsp_id=1.
3. Subtract with borrow: req0 in1=1100, in2=1111, sub=1 → rsp_out=1101, rsp_cout=0.
4. Contention:
   - Stimulus: both requesters valid from reset with rsp_ready=1, requester 0 doing 0001+0001 and requester 1 doing 0010+0010, four operations total.
   - Required response: rsp_id sequence 0,1,0,1 with results 0010, 0100, 0010, 0100; never two readies high in one cycle.
5. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_out stable, rsp_valid stays 1, req*_ready stays 0; release → exactly one handshake, then back to IDLE.
6. Reset: assert rst during EXEC with no clock edge needed → all outputs 0 immediately; after release no response appears for the aborted op, and the first tie grants requester 0.
